// File: rtl/div_arbiter_if.sv
// Signal bundle between the divider arbiter, its two requesters and the shared divider.
// The slave modport is the arbiter's view; master is the surrounding pipeline/divider.
`timescale 1ns/1ps
interface div_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [1:0]        req_valid_i;
    logic [1:0]        req_kill_i;
    logic [2:0]        req0_op_i;
    logic [2:0]        req1_op_i;
    logic [DATA_W-1:0] req0_dividend_i;
    logic [DATA_W-1:0] req1_dividend_i;
    logic [DATA_W-1:0] req0_divisor_i;
    logic [DATA_W-1:0] req1_divisor_i;
    logic [ADDR_W-1:0] req0_waddr_i;
    logic [ADDR_W-1:0] req1_waddr_i;

    logic [1:0]        grant_o;
    logic [1:0]        done_o;
    logic [DATA_W-1:0] result_o;
    logic [ADDR_W-1:0] waddr_o;
    logic              busy_o;

    logic              div_start_o;
    logic [2:0]        div_op_o;
    logic [DATA_W-1:0] div_dividend_o;
    logic [DATA_W-1:0] div_divisor_o;
    logic [ADDR_W-1:0] div_waddr_o;
    logic              div_ready_i;
    logic              div_busy_i;
    logic [DATA_W-1:0] div_result_i;

    modport slave (
        input  req_valid_i, req_kill_i,
        input  req0_op_i, req1_op_i,
        input  req0_dividend_i, req1_dividend_i,
        input  req0_divisor_i, req1_divisor_i,
        input  req0_waddr_i, req1_waddr_i,
        output grant_o, done_o, result_o, waddr_o, busy_o,
        output div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o,
        input  div_ready_i, div_busy_i, div_result_i
    );

    modport master (
        output req_valid_i, req_kill_i,
        output req0_op_i, req1_op_i,
        output req0_dividend_i, req1_dividend_i,
        output req0_divisor_i, req1_divisor_i,
        output req0_waddr_i, req1_waddr_i,
        input  grant_o, done_o, result_o, waddr_o, busy_o,
        input  div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o,
        output div_ready_i, div_busy_i, div_result_i
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin owner of a single multi-cycle divider shared by the ex stage (req0) and the
// coprocessor/debug port (req1); holds start for the whole op and drains safely on a flush.
`timescale 1ns/1ps
module div_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic              start_q, start_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] dividend_q, dividend_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [ADDR_W-1:0] div_waddr_q, div_waddr_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic [1:0]        eligible;
    logic              winner;
    logic              owner_killed;

    // A requester killed in the same cycle it asks is simply not a candidate.
    always_comb begin
        eligible     = bus.req_valid_i & ~bus.req_kill_i;
        owner_killed = |(grant_q & bus.req_kill_i);
        if (eligible == 2'b11) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~eligible[0];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        done_d       = 2'b00;
        start_d      = start_q;
        op_d         = op_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        div_waddr_d  = div_waddr_q;
        result_d     = result_q;
        waddr_d      = waddr_q;

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d      = ST_RUN;
                    last_grant_d = winner;
                    grant_d      = winner ? 2'b10 : 2'b01;
                    start_d      = 1'b1;
                    if (winner) begin
                        op_d        = bus.req1_op_i;
                        dividend_d  = bus.req1_dividend_i;
                        divisor_d   = bus.req1_divisor_i;
                        div_waddr_d = bus.req1_waddr_i;
                    end else begin
                        op_d        = bus.req0_op_i;
                        dividend_d  = bus.req0_dividend_i;
                        divisor_d   = bus.req0_divisor_i;
                        div_waddr_d = bus.req0_waddr_i;
                    end
                end
            end

            // Flush of the owner takes priority over a result arriving in the same cycle.
            ST_RUN: begin
                if (owner_killed) begin
                    state_d = ST_DRAIN;
                    start_d = 1'b0;
                    grant_d = 2'b00;
                end else if (bus.div_ready_i) begin
                    state_d  = ST_RESP;
                    start_d  = 1'b0;
                    result_d = bus.div_result_i;
                    waddr_d  = div_waddr_q;
                    done_d   = grant_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end

            ST_DRAIN: begin
                if (!bus.div_busy_i && !bus.div_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            done_q       <= 2'b00;
            start_q      <= 1'b0;
            op_q         <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            div_waddr_q  <= '0;
            result_q     <= '0;
            waddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            start_q      <= start_d;
            op_q         <= op_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            div_waddr_q  <= div_waddr_d;
            result_q     <= result_d;
            waddr_q      <= waddr_d;
        end
    end

    // Start drops combinationally with ready so the divider cannot relaunch on its own result.
    assign bus.div_start_o    = start_q & ~bus.div_ready_i;
    assign bus.div_op_o       = op_q;
    assign bus.div_dividend_o = dividend_q;
    assign bus.div_divisor_o  = divisor_q;
    assign bus.div_waddr_o    = div_waddr_q;
    assign bus.grant_o        = grant_q;
    assign bus.done_o         = done_q;
    assign bus.result_o       = result_q;
    assign bus.waddr_o        = waddr_q;
    assign bus.busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a behavioural divider plus a request-level scoreboard that
// predicts grants, results and drain behaviour from the arbitration rules.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    div_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_kill  = 2'b00;
    logic [2:0]  req_op [2];
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    logic [4:0]  req_w  [2];

    assign bus.req_valid_i     = req_valid;
    assign bus.req_kill_i      = req_kill;
    assign bus.req0_op_i       = req_op[0];
    assign bus.req1_op_i       = req_op[1];
    assign bus.req0_dividend_i = req_a[0];
    assign bus.req1_dividend_i = req_a[1];
    assign bus.req0_divisor_i  = req_b[0];
    assign bus.req1_divisor_i  = req_b[1];
    assign bus.req0_waddr_i    = req_w[0];
    assign bus.req1_waddr_i    = req_w[1];

    int vectors = 0;
    int miscompares = 0;

    // Divider semantics in the RISC-V M-extension sense, including /0 and overflow.
    function automatic logic [31:0] refDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        bit ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural divider: counts a random latency, pulses ready, aborts (or keeps going) when start drops.
    logic        div_ready  = 1'b0;
    logic        div_busy   = 1'b0;
    logic [31:0] div_result = '0;
    int          div_cnt    = 0;
    int          abort_wait = 0;
    bit          late_mode  = 1'b0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          lat_min   = 1;
    int          lat_max   = 6;
    int          late_knob = -1;

    assign bus.div_ready_i  = div_ready;
    assign bus.div_busy_i   = div_busy;
    assign bus.div_result_i = div_result;

    always @(posedge clk) begin
        div_ready <= 1'b0;
        if (rst) begin
            div_busy   <= 1'b0;
            div_cnt    <= 0;
            abort_wait <= 0;
        end else if (div_busy) begin
            if (!bus.div_start_o && !late_mode) begin
                if (abort_wait == 0) div_busy <= 1'b0;
                else abort_wait <= abort_wait - 1;
            end else if (div_cnt <= 1) begin
                div_busy   <= 1'b0;
                div_ready  <= 1'b1;
                div_result <= refDiv(m_op, m_a, m_b);
            end else begin
                div_cnt <= div_cnt - 1;
            end
        end else if (bus.div_start_o) begin
            div_busy   <= 1'b1;
            div_cnt    <= $urandom_range(lat_max, lat_min);
            m_op       <= bus.div_op_o;
            m_a        <= bus.div_dividend_o;
            m_b        <= bus.div_divisor_o;
            abort_wait <= $urandom_range(3, 0);
            late_mode  <= (late_knob < 0) ? ($urandom_range(1, 0) == 1) : (late_knob == 1);
        end
    end

    // Request-level model state.
    bit          pending [2] = '{1'b0, 1'b0};
    bit          kill_owner [2] = '{1'b0, 1'b0};
    int          done_count [2] = '{0, 0};
    int          issued = 0;
    int          completed = 0;
    int          killed = 0;
    int          last_winner = 1;
    int          grant_log [$];
    int          done_log [$];
    logic [31:0] result_log [$];
    logic [1:0]  last_done = '0;
    logic [31:0] last_result = '0;
    logic [4:0]  last_waddr = '0;
    bit          prev_busy = 1'b0;
    logic [1:0]  prev_done = '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] w);
        req_op[r]    = op;
        req_a[r]     = a;
        req_b[r]     = b;
        req_w[r]     = w;
        req_valid[r] = 1'b1;
        pending[r]   = 1'b1;
        issued++;
    endtask

    // One clock: inputs held over the posedge, outputs checked at the following negedge.
    task automatic step_cycle();
        logic [1:0] elig;
        bit         rst_edge;
        int         win;
        logic [1:0] exp_grant;
        elig     = req_valid & ~req_kill;
        rst_edge = rst;
        @(negedge clk);
        if (!rst_edge) begin
            if (!prev_busy) begin
                win       = (elig == 2'b11) ? (1 - last_winner) : (elig[0] ? 0 : 1);
                exp_grant = (elig == 2'b00) ? 2'b00 : 2'(1 << win);
                checkOutput("grant_rr", bus.grant_o, exp_grant);
                if (elig != 2'b00) begin
                    last_winner = win;
                    grant_log.push_back(win);
                    checkOutput("busy_on_grant", bus.busy_o, 1);
                end
            end
            if (prev_done != 2'b00) begin
                checkOutput("grant_clear_after_done", bus.grant_o, 0);
                checkOutput("busy_clear_after_done", bus.busy_o, 0);
            end
            if (bus.done_o != 2'b00) begin
                checkOutput("done_onehot", $countones(bus.done_o), 1);
                for (int r = 0; r < 2; r++) begin
                    if (bus.done_o[r]) begin
                        checkOutput("done_pending", pending[r], 1);
                        checkOutput("result", bus.result_o, refDiv(req_op[r], req_a[r], req_b[r]));
                        checkOutput("waddr", bus.waddr_o, req_w[r]);
                        pending[r]   = 1'b0;
                        req_valid[r] = 1'b0;
                        done_count[r]++;
                        completed++;
                        done_log.push_back(r);
                        result_log.push_back(bus.result_o);
                    end
                end
                last_done   = bus.done_o;
                last_result = bus.result_o;
                last_waddr  = bus.waddr_o;
            end
            if (bus.div_ready_i) checkOutput("start_masked_on_ready", bus.div_start_o, 0);
        end
        prev_busy = bus.busy_o;
        prev_done = bus.done_o;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((pending[0] || pending[1] || bus.busy_o) && n < budget) begin
            step_cycle();
            n++;
        end
        checkOutput("idle_within_budget", pending[0] || pending[1] || bus.busy_o, 0);
    endtask

    task automatic start_kill(input int r);
        kill_owner[r] = pending[r] && bus.grant_o[r];
        if (pending[r]) killed++;
        pending[r]   = 1'b0;
        req_valid[r] = 1'b0;
        req_kill[r]  = 1'b1;
    endtask

    task automatic finish_kills();
        for (int r = 0; r < 2; r++) begin
            if (req_kill[r] && kill_owner[r]) begin
                checkOutput("kill_grant_drop", bus.grant_o, 0);
                checkOutput("kill_drain_busy", bus.busy_o, 1);
            end
            req_kill[r]   = 1'b0;
            kill_owner[r] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int r = 0; r < 2; r++) if (pending[r]) killed++;
        pending   = '{1'b0, 1'b0};
        req_valid = 2'b00;
        req_kill  = 2'b00;
        step_cycle();
        step_cycle();
        rst         = 1'b0;
        last_winner = 1;
    endtask

    task automatic check_all_zero(input string pfx);
        checkOutput({pfx, "_grant"}, bus.grant_o, 0);
        checkOutput({pfx, "_done"}, bus.done_o, 0);
        checkOutput({pfx, "_result"}, bus.result_o, 0);
        checkOutput({pfx, "_waddr"}, bus.waddr_o, 0);
        checkOutput({pfx, "_busy"}, bus.busy_o, 0);
        checkOutput({pfx, "_start"}, bus.div_start_o, 0);
        checkOutput({pfx, "_div_op"}, bus.div_op_o, 0);
        checkOutput({pfx, "_div_dividend"}, bus.div_dividend_o, 0);
        checkOutput({pfx, "_div_divisor"}, bus.div_divisor_o, 0);
        checkOutput({pfx, "_div_waddr"}, bus.div_waddr_o, 0);
    endtask

    function automatic logic [2:0] rand_op();
        return OP_DIV + 3'($urandom_range(3, 0));
    endfunction

    function automatic logic [31:0] rand_dividend();
        return ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : 32'($urandom());
    endfunction

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(7, 0))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(15, 1));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        int n3;
        bit saw_idle_div;
        int d0;
        int d1;
        for (int r = 0; r < 2; r++) begin
            req_op[r] = '0;
            req_a[r]  = '0;
            req_b[r]  = '0;
            req_w[r]  = '0;
        end
        $display("[TB] start");

        do_reset();
        check_all_zero("reset");

        // DIVU 100/7 from req0
        applyStimulus(0, OP_DIVU, 32'd100, 32'd7, 5'd5);
        wait_idle(100);
        checkOutput("t1_done", last_done, 2'b01);
        checkOutput("t1_result", last_result, 32'd14);
        checkOutput("t1_waddr", last_waddr, 5'd5);
        checkOutput("t1_busy", bus.busy_o, 0);

        // Both valid straight out of reset: req0 first
        do_reset();
        done_log.delete();
        result_log.delete();
        applyStimulus(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd3);
        applyStimulus(1, OP_DIV, 32'd20, 32'd4, 5'd9);
        wait_idle(200);
        checkOutput("t2_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            checkOutput("t2_first_owner", done_log[0], 0);
            checkOutput("t2_first_result", result_log[0], 32'hFFFF_FFFF);
            checkOutput("t2_second_owner", done_log[1], 1);
            checkOutput("t2_second_result", result_log[1], 32'd5);
        end

        // Both held valid for four operations
        grant_log.delete();
        n3 = 0;
        for (int cyc = 0; cyc < 400 && (n3 < 4 || pending[0] || pending[1]); cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && !pending[r] && n3 < 4) begin
                    applyStimulus(r, rand_op(), rand_dividend(), rand_divisor(), 5'($urandom()));
                    n3++;
                end
            end
            step_cycle();
        end
        wait_idle(100);
        checkOutput("t3_grants", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) checkOutput("t3_alternate", grant_log[i], i % 2);

        // Divide-by-zero from req1; second op drops valid once owned
        applyStimulus(1, OP_DIV, 32'($urandom()), 32'd0, 5'd17);
        wait_idle(100);
        checkOutput("t4_div0_done", last_done, 2'b10);
        checkOutput("t4_div0_result", last_result, 32'hFFFF_FFFF);
        applyStimulus(1, OP_REMU, 32'd9, 32'd0, 5'd18);
        for (int i = 0; i < 10 && bus.grant_o != 2'b10; i++) step_cycle();
        req_valid[1] = 1'b0;
        wait_idle(100);
        checkOutput("t4_remu_done", last_done, 2'b10);
        checkOutput("t4_remu_result", last_result, 32'd9);

        // Flush of req0 mid-run with a long divider that keeps running; req1 queued behind it
        lat_min   = 10;
        lat_max   = 10;
        late_knob = 1;
        d0 = done_count[0];
        d1 = done_count[1];
        applyStimulus(0, OP_DIV, rand_dividend(), 32'd3, 5'd1);
        for (int i = 0; i < 10 && bus.grant_o != 2'b01; i++) step_cycle();
        applyStimulus(1, OP_DIVU, 32'd81, 32'd9, 5'd2);
        for (int i = 0; i < 3; i++) step_cycle();
        checkOutput("t5_running", bus.div_start_o, 1);
        start_kill(0);
        step_cycle();
        finish_kills();
        saw_idle_div = 1'b0;
        for (int i = 0; i < 40 && bus.grant_o != 2'b10; i++) begin
            if (!bus.div_busy_i && !bus.div_ready_i) saw_idle_div = 1'b1;
            step_cycle();
        end
        checkOutput("t5_req1_granted", bus.grant_o, 2'b10);
        checkOutput("t5_drained_first", saw_idle_div, 1);
        wait_idle(100);
        checkOutput("t5_no_done_req0", done_count[0], d0);
        checkOutput("t5_req1_served", done_count[1], d1 + 1);
        checkOutput("t5_req1_result", last_result, 32'd9);

        // Reset in the middle of a run
        late_knob = -1;
        lat_min   = 8;
        lat_max   = 8;
        applyStimulus(0, rand_op(), rand_dividend(), rand_divisor(), 5'd30);
        for (int i = 0; i < 10 && bus.grant_o != 2'b01; i++) step_cycle();
        step_cycle();
        step_cycle();
        checkOutput("t6_prerst_busy", bus.busy_o, 1);
        rst = 1'b1;
        step_cycle();
        check_all_zero("t6_rst");
        do_reset();

        // Randomized traffic with kills and silent valid drops
        lat_min = 1;
        lat_max = 6;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && !pending[r]) begin
                    if ($urandom_range(2, 0) == 0)
                        applyStimulus(r, rand_op(), rand_dividend(), rand_divisor(), 5'($urandom()));
                end else if (req_valid[r]) begin
                    if ($urandom_range(24, 0) == 0) start_kill(r);
                    else if (bus.grant_o[r] && $urandom_range(29, 0) == 0) req_valid[r] = 1'b0;
                end
            end
            step_cycle();
            finish_kills();
        end
        wait_idle(300);
        checkOutput("accounting", completed + killed, issued);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
